// File: rtl/mac_beams_ctrl.sv
// Beam MAC sequencer: gates antenna valid, counts REs, swaps codeword banks at symbol starts, tags array output.
// Latency: o_rvalid/o_re_idx 2 cycles, o_cw_bank/ack 1 cycle, output tags 1 cycle; optional MAC_BEAMS_CTRL_ERR_EN builds sticky o_err.
// Backpressure: none; stray samples are dropped and tag pushes into a full FIFO are discarded.
module mac_beams_ctrl #(
    parameter int RE_NUM     = 1584,
    parameter int SYM_NUM    = 14,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_sym_start,
    input  logic                      i_rvalid,
    input  logic                      i_cw_swap_req,
    output logic                      o_cw_swap_ack,
    output logic                      o_cw_bank,
    output logic                      o_rvalid,
    output logic [$clog2(RE_NUM)-1:0] o_re_idx,
    input  logic                      i_mac_tvalid,
    output logic                      o_tvalid,
    output logic                      o_sop,
    output logic                      o_eop,
    output logic [3:0]                o_sym_idx,
    output logic                      o_busy,
    output logic [2:0]                o_err
);
    localparam int RE_W = $clog2(RE_NUM);
    localparam int CW   = RE_W + 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   in_cnt, in_cnt_nxt, cnt_inc;
    logic            start_acc, acc;
    logic [RE_W-1:0] acc_idx;

    logic            rv_d1;
    logic [RE_W-1:0] idx_d1;
    logic            pend;
    logic [3:0]      sym_cnt;

    logic            tag_rdy, tag_push, tag_vld, tag_pop, tag_last;
    logic [3:0]      tag_dat;
    logic [CW-1:0]   out_cnt;

    assign start_acc = i_sym_start & i_rvalid;
    assign acc       = i_rvalid & (i_sym_start | (state == RUN));

    always_comb begin
        state_nxt  = state;
        in_cnt_nxt = in_cnt;
        cnt_inc    = '0;
        acc_idx    = '0;
        if (acc) begin
            // a start always restarts the count, abandoning any symbol in progress
            cnt_inc = i_sym_start ? CW'(1) : in_cnt + CW'(1);
            acc_idx = i_sym_start ? '0 : in_cnt[RE_W-1:0];
            if (cnt_inc == CW'(RE_NUM)) begin
                state_nxt  = IDLE;
                in_cnt_nxt = '0;
            end else begin
                state_nxt  = RUN;
                in_cnt_nxt = cnt_inc;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state  <= IDLE;
            in_cnt <= '0;
        end else begin
            state  <= state_nxt;
            in_cnt <= in_cnt_nxt;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rv_d1    <= 1'b0;
            idx_d1   <= '0;
            o_rvalid <= 1'b0;
            o_re_idx <= '0;
        end else begin
            rv_d1    <= acc;
            idx_d1   <= acc_idx;
            o_rvalid <= rv_d1;
            o_re_idx <= idx_d1;
        end
    end

    // bank flips one cycle after the start, lining up with the array's codeword register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pend          <= 1'b0;
            o_cw_bank     <= 1'b0;
            o_cw_swap_ack <= 1'b0;
            sym_cnt       <= '0;
        end else begin
            if (start_acc) begin
                o_cw_swap_ack <= pend | i_cw_swap_req;
                o_cw_bank     <= o_cw_bank ^ (pend | i_cw_swap_req);
                pend          <= 1'b0;
                sym_cnt       <= (sym_cnt == 4'(SYM_NUM - 1)) ? 4'd0 : sym_cnt + 4'd1;
            end else begin
                o_cw_swap_ack <= 1'b0;
                pend          <= pend | i_cw_swap_req;
            end
        end
    end

    assign tag_push = start_acc & tag_rdy;
    assign tag_last = (out_cnt == CW'(RE_NUM - 1));
    assign tag_pop  = i_mac_tvalid & tag_vld & tag_last;

    mac_beams_fifo #(
        .W     (4),
        .DEPTH (FIFO_DEPTH)
    ) u_tag_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .in_vld  (tag_push),
        .in_rdy  (tag_rdy),
        .in_dat  (sym_cnt),
        .out_vld (tag_vld),
        .out_rdy (tag_pop),
        .out_dat (tag_dat)
    );

    // untagged output (FIFO empty) passes through without advancing the RE count
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            out_cnt   <= '0;
            o_tvalid  <= 1'b0;
            o_sop     <= 1'b0;
            o_eop     <= 1'b0;
            o_sym_idx <= '0;
            o_busy    <= 1'b0;
        end else begin
            o_tvalid  <= i_mac_tvalid;
            o_sop     <= i_mac_tvalid & tag_vld & (out_cnt == '0);
            o_eop     <= tag_pop;
            o_sym_idx <= (i_mac_tvalid & tag_vld) ? tag_dat : 4'd0;
            o_busy    <= (state != IDLE) | tag_vld;
            if (i_mac_tvalid & tag_vld)
                out_cnt <= tag_last ? '0 : out_cnt + CW'(1);
        end
    end

`ifdef MAC_BEAMS_CTRL_ERR_EN
    logic [2:0] err_q;
    logic       ev_drop, ev_short, ev_ovf;

    assign ev_drop  = i_rvalid & ~i_sym_start & (state == IDLE);
    assign ev_short = start_acc & (state == RUN);
    assign ev_ovf   = start_acc & ~tag_rdy;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            err_q <= '0;
        else
            err_q <= err_q | {ev_ovf, ev_short, ev_drop};
    end
    assign o_err = err_q;
`else
    assign o_err = 3'b000;
`endif

endmodule

// Generic valid/ready FIFO; a pop in the same cycle frees room for a push when full.
// Latency: 1 cycle push-to-head; backpressure via in_rdy deasserted when full and not popping.
// Backpressure: producer must hold in_vld until in_rdy, or accept the push being discarded.
module mac_beams_fifo #(
    parameter int W     = 4,
    parameter int DEPTH = 4
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         in_vld,
    output logic         in_rdy,
    input  logic [W-1:0] in_dat,
    output logic         out_vld,
    input  logic         out_rdy,
    output logic [W-1:0] out_dat
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   cnt;
    logic          push, pop;

    assign out_vld = (cnt != '0);
    assign in_rdy  = (cnt != (AW+1)'(DEPTH)) | out_rdy;
    assign push    = in_vld & in_rdy;
    assign pop     = out_vld & out_rdy;
    assign out_dat = mem[rd_ptr];

    always_ff @(posedge i_clk) begin
        if (push)
            mem[wr_ptr] <= in_dat;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

endmodule

// File: tb/tb_mac_beams_ctrl.sv
// Directed bench for mac_beams_ctrl with RE_NUM=8, SYM_NUM=14, FIFO_DEPTH=4.
module tb_mac_beams_ctrl;
    localparam int RE  = 8;
    localparam int SYM = 14;
`ifdef MAC_BEAMS_CTRL_ERR_EN
    localparam bit ERR_ON = 1'b1;
`else
    localparam bit ERR_ON = 1'b0;
`endif

    logic       i_clk = 1'b0;
    logic       i_rst_n = 1'b0;
    logic       i_sym_start = 1'b0;
    logic       i_rvalid = 1'b0;
    logic       i_cw_swap_req = 1'b0;
    logic       i_mac_tvalid = 1'b0;
    logic       o_cw_swap_ack, o_cw_bank, o_rvalid;
    logic [2:0] o_re_idx;
    logic       o_tvalid, o_sop, o_eop, o_busy;
    logic [3:0] o_sym_idx;
    logic [2:0] o_err;

    int checks = 0;
    int errors = 0;

    logic pend_vld = 1'b0;
    logic pend_rv  = 1'b0;
    int   pend_idx = 0;
    logic bank_a, ack_a;

    mac_beams_ctrl #(.RE_NUM(RE), .SYM_NUM(SYM), .FIFO_DEPTH(4)) dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_sym_start   (i_sym_start),
        .i_rvalid      (i_rvalid),
        .i_cw_swap_req (i_cw_swap_req),
        .o_cw_swap_ack (o_cw_swap_ack),
        .o_cw_bank     (o_cw_bank),
        .o_rvalid      (o_rvalid),
        .o_re_idx      (o_re_idx),
        .i_mac_tvalid  (i_mac_tvalid),
        .o_tvalid      (o_tvalid),
        .o_sop         (o_sop),
        .o_eop         (o_eop),
        .o_sym_idx     (o_sym_idx),
        .o_busy        (o_busy),
        .o_err         (o_err)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // one input cycle; the gated valid for these inputs is checked on the next call
    task automatic drive(input logic st, input logic rv, input logic req, input logic erv, input int eidx);
        i_sym_start   = st;
        i_rvalid      = rv;
        i_cw_swap_req = req;
        tick();
        if (pend_vld) begin
            chk("o_rvalid", 32'(o_rvalid), 32'(pend_rv));
            if (pend_rv)
                chk("o_re_idx", 32'(o_re_idx), 32'(pend_idx));
        end
        pend_vld = 1'b1;
        pend_rv  = erv;
        pend_idx = eidx;
    endtask

    task automatic flush();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 0);
    endtask

    task automatic run_sym(input int n, input logic req0, input int mreq, output logic bank, output logic ack);
        drive(1'b1, 1'b1, req0, 1'b1, 0);
        bank = o_cw_bank;
        ack  = o_cw_swap_ack;
        for (int i = 1; i < n; i++)
            drive(1'b0, 1'b1, (i == mreq) || (i == mreq + 1), 1'b1, i);
    endtask

    task automatic out_run(input int exp_sym);
        i_sym_start   = 1'b0;
        i_rvalid      = 1'b0;
        i_cw_swap_req = 1'b0;
        pend_vld      = 1'b0;
        for (int k = 0; k < RE; k++) begin
            i_mac_tvalid = 1'b1;
            tick();
            chk("out_tag", {o_tvalid, o_sop, o_eop, o_sym_idx},
                {1'b1, k == 0, k == RE - 1, 4'(exp_sym)});
        end
        i_mac_tvalid = 1'b0;
    endtask

    task automatic do_reset();
        i_rst_n       = 1'b0;
        i_sym_start   = 1'b0;
        i_rvalid      = 1'b0;
        i_cw_swap_req = 1'b0;
        i_mac_tvalid  = 1'b0;
        pend_vld      = 1'b0;
        tick();
        tick();
        i_rst_n = 1'b1;
        tick();
    endtask

    initial begin
        // reset state
        tick();
        tick();
        chk("reset_outputs", {o_cw_swap_ack, o_cw_bank, o_rvalid, o_re_idx, o_tvalid, o_sop,
                              o_eop, o_sym_idx, o_busy, o_err}, 32'h0);
        i_rst_n = 1'b1;
        tick();

        // two back-to-back symbols, then their tagged output
        run_sym(RE, 1'b0, -1, bank_a, ack_a);
        chk("busy_running", 32'(o_busy), 32'h1);
        run_sym(RE, 1'b0, -1, bank_a, ack_a);
        flush();
        out_run(0);
        out_run(1);
        tick();
        chk("busy_drained", 32'(o_busy), 32'h0);

        // request three cycles ahead of a start
        drive(1'b0, 1'b0, 1'b1, 1'b0, 0);
        chk("bank_before_start", {o_cw_bank, o_cw_swap_ack}, 2'b00);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 0);
        run_sym(RE, 1'b0, 3, bank_a, ack_a);
        chk("swap_apply", {bank_a, ack_a}, 2'b11);
        chk("bank_hold_midsym", {o_cw_bank, o_cw_swap_ack}, 2'b10);
        // double request absorbed into one swap
        run_sym(RE, 1'b0, -1, bank_a, ack_a);
        chk("swap_pending", {bank_a, ack_a}, 2'b01);
        // request coincident with the start
        run_sym(RE, 1'b1, -1, bank_a, ack_a);
        chk("swap_coincident", {bank_a, ack_a}, 2'b11);
        run_sym(RE, 1'b0, -1, bank_a, ack_a);
        chk("no_swap", {bank_a, ack_a}, 2'b10);
        flush();
        chk("err_full_no_ovf", 32'(o_err), 32'h0);
        out_run(2);
        out_run(3);
        out_run(4);
        out_run(5);

        // stray valids from IDLE
        drive(1'b0, 1'b1, 1'b0, 1'b0, 0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 0);
        flush();
        chk("err_drop", 32'(o_err), ERR_ON ? 32'h1 : 32'h0);

        // short symbol of 5 REs, restart into a full symbol
        run_sym(5, 1'b0, -1, bank_a, ack_a);
        run_sym(RE, 1'b0, -1, bank_a, ack_a);
        flush();
        chk("err_short", 32'(o_err), ERR_ON ? 32'h3 : 32'h0);
        out_run(6);
        out_run(7);

        // five symbols into a depth-4 tag FIFO
        do_reset();
        chk("err_after_reset", 32'(o_err), 32'h0);
        for (int s = 0; s < 5; s++)
            run_sym(RE, 1'b0, -1, bank_a, ack_a);
        flush();
        chk("err_ovf", 32'(o_err), ERR_ON ? 32'h4 : 32'h0);
        out_run(0);
        out_run(1);
        out_run(2);
        out_run(3);
        i_mac_tvalid = 1'b1;
        tick();
        chk("untagged_pass", {o_tvalid, o_sop, o_eop, o_sym_idx}, 7'b1000000);
        i_mac_tvalid = 1'b0;
        tick();
        chk("untagged_idle", {o_tvalid, o_busy}, 2'b00);

        // symbol index wrap over 15 symbols
        do_reset();
        for (int s = 0; s < 15; s++) begin
            run_sym(RE, 1'b0, -1, bank_a, ack_a);
            flush();
            out_run(s % SYM);
        end

        // asynchronous reset mid-symbol
        run_sym(3, 1'b0, -1, bank_a, ack_a);
        i_mac_tvalid = 1'b1;
        drive(1'b0, 1'b1, 1'b0, 1'b1, 3);
        chk("pre_reset_active", {o_tvalid, o_sop, o_busy}, 3'b111);
        #2;
        i_rst_n = 1'b0;
        #1;
        chk("async_reset_now", {o_cw_swap_ack, o_cw_bank, o_rvalid, o_re_idx, o_tvalid, o_sop,
                                o_eop, o_sym_idx, o_busy, o_err}, 32'h0);
        tick();
        chk("async_reset_edge", {o_cw_swap_ack, o_cw_bank, o_rvalid, o_re_idx, o_tvalid, o_sop,
                                 o_eop, o_sym_idx, o_busy, o_err}, 32'h0);
        do_reset();
        run_sym(RE, 1'b0, -1, bank_a, ack_a);
        chk("post_reset_bank", {bank_a, ack_a}, 2'b00);
        flush();
        out_run(0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mac_beams_ctrl.md
# mac_beams_ctrl

Symbol-level sequencer for the beam MAC array. It gates the antenna-sample valid into the array and counts resource elements (REs) per symbol. It selects the ping-pong codeword bank and applies bank swaps only at symbol boundaries. It also tags the array's output stream with start-of-symbol, end-of-symbol and symbol index markers, using a small in-flight symbol FIFO.

## Interface
- RE_NUM, 1584 — REs (valid samples) per symbol
- SYM_NUM, 14 — symbols per slot; symbol index wraps at SYM_NUM-1
- FIFO_DEPTH, 4 — in-flight symbol tag FIFO depth (power of 2)

- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_sym_start  in  1  pulse, coincides with first i_rvalid of a symbol
- i_rvalid  in  1  upstream antenna-sample valid
- i_cw_swap_req  in  1  pulse: shadow codeword bank loaded, swap requested
- o_cw_swap_ack  out  1  pulse: swap applied
- o_cw_bank  out  1  active codeword bank select to codeword mux
- o_rvalid  out  1  gated valid to the MAC array
- o_re_idx  out  $clog2(RE_NUM)  RE index of the sample carried by o_rvalid
- i_mac_tvalid  in  1  output valid from the MAC array
- o_tvalid  out  1  tagged output valid
- o_sop  out  1  first RE of output symbol
- o_eop  out  1  last RE of output symbol
- o_sym_idx  out  4  symbol index of current output RE
- o_busy  out  1  input state not IDLE or tag FIFO non-empty
- o_err  out  3  sticky {fifo_ovf, short_sym, drop}

## Operation
- Input FSM states: IDLE and RUN.
  - IDLE, with i_sym_start & i_rvalid: go to RUN. RE counter is set to 1. The symbol index is pushed to the tag FIFO.
  - RUN: each i_rvalid increments the RE counter. On the valid that completes RE_NUM REs, return to IDLE.
  - Back-to-back symbols: a completing sample followed next cycle by i_sym_start is legal, with no bubble required.
- i_sym_start with i_rvalid in RUN before RE_NUM REs are counted: short symbol.
  - Set err[1].
  - Abandon the current symbol; its tag stays queued.
  - Restart the counter at 1, push the new tag and remain in RUN.
- i_rvalid in IDLE without i_sym_start: the sample is dropped. o_rvalid stays 0 and err[0] is set.
- i_sym_start without i_rvalid is ignored.
- Symbol index increments on each accepted start and wraps SYM_NUM-1 → 0.
- Codeword swap:
  - i_cw_swap_req sets a pending flag.
  - On the next accepted i_sym_start, o_cw_bank toggles, pending clears and o_cw_swap_ack pulses.
  - A request in the same cycle as an accepted start applies to that symbol.
  - A second request while pending is absorbed.
  - The bank never changes mid-symbol.
- Output side:
  - An RE counter counts i_mac_tvalid.
  - The first count asserts o_sop and presents the FIFO head as o_sym_idx.
  - Count RE_NUM asserts o_eop and pops the FIFO.
  - Push and pop in the same cycle keep the occupancy unchanged.
  - A push when full is dropped and sets err[2].
  - i_mac_tvalid with the FIFO empty passes through with o_sym_idx=0 and no sop/eop.
- Reset values: all outputs 0, FSM in IDLE, o_cw_bank=0, pending=0, FIFO empty, symbol index 0.
- Reset asserted mid-symbol aborts everything immediately, asynchronously.

## Timing
- o_rvalid and o_re_idx: 2 cycles after i_rvalid. The antenna data path must be delayed by 2 cycles externally.
- o_cw_bank: changes 1 cycle after the accepted i_sym_start, i.e. exactly 1 cycle before the first o_rvalid of that symbol. This matches the array's 1-cycle codeword register.
- o_cw_swap_ack: 1 cycle after the accepted start, in the same cycle o_cw_bank toggles.
- o_tvalid, o_sop, o_eop, o_sym_idx: registered, 1 cycle after i_mac_tvalid.
- Error bits: set 1 cycle after the event and cleared only by reset.
- o_busy: registered.

## Configuration
- MAC_BEAMS_CTRL_ERR_EN defined:
  - Sticky error logic is built.
  - Drop, short-symbol and overflow handling update o_err as above.
- MAC_BEAMS_CTRL_ERR_EN undefined:
  - o_err is tied to 0.
  - Functional handling (dropping, restart, FIFO overflow discard) is unchanged.

## Test plan
- RE_NUM=8, SYM_NUM=14, two back-to-back symbols of 8 contiguous valids:
  - o_rvalid is 16 cycles, 2 cycles late, with o_re_idx 0..7 twice.
  - After the array latency, output shows sop/eop at REs 0/7 with o_sym_idx 0 then 1.
- i_cw_swap_req 3 cycles before a start:
  - o_cw_bank toggles 0→1 one cycle before that symbol's first o_rvalid.
  - ack pulses once.
  - Request coincident with a start gives the same result for that symbol.
- 3 valids without i_sym_start from IDLE: o_rvalid stays 0 and o_err=3'b001.
- New start after 5 of 8 REs:
  - o_err[1]=1 and o_re_idx restarts at 0.
  - The new symbol is 8 REs with the next symbol index.
- Hold i_mac_tvalid low while sending 5 symbols with FIFO_DEPTH=4: o_err[2]=1, and output tags read 0,1,2,3.
- 15 symbols: o_sym_idx runs 0..13 then 0. Assert i_rst_n low mid-symbol: all outputs 0 next edge, o_busy=0.
